control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Six-state microinstruction sequencer for a small bus-based CPU.
// Walks IDLE -> T1..T6 per instruction, decodes the opcode during T4..T6
// into active-high load/enable strobes, parks in HALT on the HLT opcode,
// and counts retired instructions.
module control_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    pc_inc,
    output logic                    pc_en,
    output logic                    mar_load,
    output logic                    ram_en,
    output logic                    ir_load,
    output logic                    ir_en,
    output logic                    a_load,
    output logic                    a_en,
    output logic                    b_load,
    output logic                    alu_en,
    output logic                    alu_sub,
    output logic                    out_load,
    output logic                    halt,
    output logic [2:0]              t_state,
    output logic                    instr_done,
    output logic [COUNT_WIDTH-1:0]  instr_count
);

    // State encoding doubles as the externally visible t_state code.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_T6   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    // Instruction class after opcode decode; anything unrecognised is a NOP.
    typedef enum logic [2:0] {
        K_LDA,
        K_ADD,
        K_SUB,
        K_OUT,
        K_HLT,
        K_NOP
    } op_kind_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'b0000);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'b0001);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'b0010);
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'b1110);
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'b1111);

    state_t   state;
    state_t   next_state;
    op_kind_t op_kind;

    // Classify the opcode field into one instruction kind.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        op_kind = K_NOP;
        case (opcode)
            OP_LDA:  op_kind = K_LDA;
            OP_ADD:  op_kind = K_ADD;
            OP_SUB:  op_kind = K_SUB;
            OP_OUT:  op_kind = K_OUT;
            OP_HLT:  op_kind = K_HLT;
            default: op_kind = K_NOP;
        endcase
    end

    // Next-state logic: advance only while run is high; HALT is sticky.
    always_comb begin
        next_state = state;
        if (run && (state != S_HALT)) begin
            case (state)
                S_IDLE:  next_state = S_T1;
                S_T1:    next_state = S_T2;
                S_T2:    next_state = S_T3;
                S_T3:    next_state = S_T4;
                S_T4:    next_state = (op_kind == K_HLT) ? S_HALT : S_T5;
                S_T5:    next_state = S_T6;
                S_T6:    next_state = S_T1;
                default: next_state = state;
            endcase
        end
    end

    // State register; reset wins over run and over every transition.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values, independent of block ordering.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Control decode: gated by run so a paused cycle never repeats a pulse.
    always_comb begin
        pc_inc   = 1'b0;
        pc_en    = 1'b0;
        mar_load = 1'b0;
        ram_en   = 1'b0;
        ir_load  = 1'b0;
        ir_en    = 1'b0;
        a_load   = 1'b0;
        a_en     = 1'b0;
        b_load   = 1'b0;
        alu_en   = 1'b0;
        alu_sub  = 1'b0;
        out_load = 1'b0;
        if (run) begin
            case (state)
                // Fetch: PC -> MAR, bump PC, RAM -> IR.
                S_T1: begin
                    pc_en    = 1'b1;
                    mar_load = 1'b1;
                end
                S_T2: begin
                    pc_inc = 1'b1;
                end
                S_T3: begin
                    ram_en  = 1'b1;
                    ir_load = 1'b1;
                end
                // Execute: operand address to MAR, or A to the output port.
                S_T4: begin
                    case (op_kind)
                        K_LDA, K_ADD, K_SUB: begin
                            ir_en    = 1'b1;
                            mar_load = 1'b1;
                        end
                        K_OUT: begin
                            a_en     = 1'b1;
                            out_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                // Operand read: into A for LDA, into B for arithmetic.
                S_T5: begin
                    case (op_kind)
                        K_LDA: begin
                            ram_en = 1'b1;
                            a_load = 1'b1;
                        end
                        K_ADD, K_SUB: begin
                            ram_en = 1'b1;
                            b_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                // Write-back of the ALU result into A.
                S_T6: begin
                    if ((op_kind == K_ADD) || (op_kind == K_SUB)) begin
                        alu_en = 1'b1;
                        a_load = 1'b1;
                        alu_sub = (op_kind == K_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign t_state    = state;
    assign halt       = (state == S_HALT);
    assign instr_done = run && (state == S_T6);

    // Retired-instruction counter; wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count <= '0;
        end else if (instr_done) begin
            instr_count <= instr_count + COUNT_WIDTH'(1);
        end
    end

    // At most one driver on the shared bus in any cycle.
    a_bus_exclusive: assert property (@(posedge clk) disable iff (rst)
        $countones({a_en, ir_en, pc_en, ram_en}) <= 1);

    // A halted machine drives no control lines.
    a_halt_quiet: assert property (@(posedge clk) disable iff (rst)
        halt |-> !(pc_inc | pc_en | mar_load | ram_en | ir_load | ir_en |
                   a_load | a_en | b_load | alu_en | alu_sub | out_load));

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: stimulus vectors carry their
// expected outputs, which pass through a scoreboard queue and are compared
// mid-cycle against the DUT; bus exclusivity is watched every cycle.
module tb_control_sequencer;

    localparam logic [11:0] PC_INC   = 12'h800;
    localparam logic [11:0] PC_EN    = 12'h400;
    localparam logic [11:0] MAR_LOAD = 12'h200;
    localparam logic [11:0] RAM_EN   = 12'h100;
    localparam logic [11:0] IR_LOAD  = 12'h080;
    localparam logic [11:0] IR_EN    = 12'h040;
    localparam logic [11:0] A_LOAD   = 12'h020;
    localparam logic [11:0] A_EN     = 12'h010;
    localparam logic [11:0] B_LOAD   = 12'h008;
    localparam logic [11:0] ALU_EN   = 12'h004;
    localparam logic [11:0] ALU_SUB  = 12'h002;
    localparam logic [11:0] OUT_LOAD = 12'h001;

    localparam logic [3:0] LDA = 4'b0000;
    localparam logic [3:0] ADD = 4'b0001;
    localparam logic [3:0] SUB = 4'b0010;
    localparam logic [3:0] OUT = 4'b1110;
    localparam logic [3:0] HLT = 4'b1111;
    localparam logic [3:0] NOP = 4'b0101;

    typedef struct {
        logic        rst;
        logic        run;
        logic [3:0]  op;
        logic        chk;
        logic [2:0]  t;
        logic [11:0] ctrl;
        logic        done;
    } vec_t;

    typedef struct {
        logic        chk;
        logic [2:0]  t;
        logic [11:0] ctrl;
        logic        hlt;
        logic        done;
        logic [7:0]  count;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       run;
    logic [3:0] opcode;
    logic pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en;
    logic a_load, a_en, b_load, alu_en, alu_sub, out_load;
    logic       halt;
    logic [2:0] t_state;
    logic       instr_done;
    logic [7:0] instr_count;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;
    logic [7:0] model_count = '0;
    exp_t exp_q[$];
    vec_t tbl[$];

    control_sequencer #(.OPCODE_WIDTH(4), .COUNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .pc_inc(pc_inc), .pc_en(pc_en), .mar_load(mar_load), .ram_en(ram_en),
        .ir_load(ir_load), .ir_en(ir_en), .a_load(a_load), .a_en(a_en),
        .b_load(b_load), .alu_en(alu_en), .alu_sub(alu_sub), .out_load(out_load),
        .halt(halt), .t_state(t_state), .instr_done(instr_done),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t r;
        @(negedge clk);
        rst    = v.rst;
        run    = v.run;
        opcode = v.op;
        e.chk   = v.chk;
        e.t     = v.t;
        e.ctrl  = v.ctrl;
        e.hlt   = (v.t == 3'd7);
        e.done  = v.done;
        e.count = model_count;
        exp_q.push_back(e);
        if (v.rst) model_count = '0;
        else if (v.done) model_count = model_count + 8'd1;
        #1;
        r = exp_q.pop_front();
        if (r.chk) begin
            check("t_state", 32'(t_state), 32'(r.t));
            check("ctrl", 32'({pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en,
                               a_load, a_en, b_load, alu_en, alu_sub, out_load}),
                  32'(r.ctrl));
            check("halt", 32'(halt), 32'(r.hlt));
            check("instr_done", 32'(instr_done), 32'(r.done));
            check("instr_count", 32'(instr_count), 32'(r.count));
        end
    endtask

    task automatic s(input logic r, input logic rn, input logic [3:0] op,
                     input logic [2:0] t, input logic [11:0] c, input logic d);
        vec_t v;
        v.rst = r; v.run = rn; v.op = op; v.chk = 1'b1;
        v.t = t; v.ctrl = c; v.done = d;
        step(v);
    endtask

    task automatic add(input logic rn, input logic [3:0] op,
                       input logic [2:0] t, input logic [11:0] c, input logic d);
        vec_t v;
        v.rst = 1'b0; v.run = rn; v.op = op; v.chk = 1'b1;
        v.t = t; v.ctrl = c; v.done = d;
        tbl.push_back(v);
    endtask

    // Reset with run held high, then confirm the idle state one cycle later.
    task automatic do_reset();
        vec_t v;
        v.rst = 1'b1; v.run = 1'b1; v.op = NOP; v.chk = 1'b0;
        v.t = 3'd0; v.ctrl = '0; v.done = 1'b0;
        step(v);
        s(1'b0, 1'b0, NOP, 3'd0, 12'h000, 1'b0);
    endtask

    // Full six-cycle instruction starting in T1 with run held high.
    task automatic run_instr(input logic [3:0] op, input logic [11:0] c4,
                             input logic [11:0] c5, input logic [11:0] c6);
        s(1'b0, 1'b1, op, 3'd1, PC_EN | MAR_LOAD, 1'b0);
        s(1'b0, 1'b1, op, 3'd2, PC_INC, 1'b0);
        s(1'b0, 1'b1, op, 3'd3, RAM_EN | IR_LOAD, 1'b0);
        s(1'b0, 1'b1, op, 3'd4, c4, 1'b0);
        s(1'b0, 1'b1, op, 3'd5, c5, 1'b0);
        s(1'b0, 1'b1, op, 3'd6, c6, 1'b1);
    endtask

    // Bus exclusivity monitored every cycle once the DUT is out of reset.
    always @(negedge clk) begin
        #2;
        if (mon_en)
            check("bus_exclusive", 32'($countones({a_en, ir_en, pc_en, ram_en}) <= 1), 32'd1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        run = 1'b0;
        opcode = NOP;

        do_reset();
        mon_en = 1'b1;

        // LDA from IDLE, then SUB with pauses in T2 and T6.
        add(1'b1, LDA, 3'd0, 12'h000, 1'b0);
        add(1'b1, LDA, 3'd1, PC_EN | MAR_LOAD, 1'b0);
        add(1'b1, LDA, 3'd2, PC_INC, 1'b0);
        add(1'b1, LDA, 3'd3, RAM_EN | IR_LOAD, 1'b0);
        add(1'b1, LDA, 3'd4, IR_EN | MAR_LOAD, 1'b0);
        add(1'b1, LDA, 3'd5, RAM_EN | A_LOAD, 1'b0);
        add(1'b1, LDA, 3'd6, 12'h000, 1'b1);
        add(1'b0, LDA, 3'd1, 12'h000, 1'b0);
        add(1'b1, SUB, 3'd1, PC_EN | MAR_LOAD, 1'b0);
        add(1'b0, SUB, 3'd2, 12'h000, 1'b0);
        add(1'b0, SUB, 3'd2, 12'h000, 1'b0);
        add(1'b0, SUB, 3'd2, 12'h000, 1'b0);
        add(1'b1, SUB, 3'd2, PC_INC, 1'b0);
        add(1'b1, SUB, 3'd3, RAM_EN | IR_LOAD, 1'b0);
        add(1'b1, SUB, 3'd4, IR_EN | MAR_LOAD, 1'b0);
        add(1'b1, SUB, 3'd5, RAM_EN | B_LOAD, 1'b0);
        add(1'b0, SUB, 3'd6, 12'h000, 1'b0);
        add(1'b1, SUB, 3'd6, ALU_EN | A_LOAD | ALU_SUB, 1'b1);
        add(1'b0, SUB, 3'd1, 12'h000, 1'b0);
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // OUT then HLT; a paused T4 must not halt.
        do_reset();
        s(1'b0, 1'b1, OUT, 3'd0, 12'h000, 1'b0);
        run_instr(OUT, A_EN | OUT_LOAD, 12'h000, 12'h000);
        s(1'b0, 1'b1, HLT, 3'd1, PC_EN | MAR_LOAD, 1'b0);
        s(1'b0, 1'b1, HLT, 3'd2, PC_INC, 1'b0);
        s(1'b0, 1'b1, HLT, 3'd3, RAM_EN | IR_LOAD, 1'b0);
        s(1'b0, 1'b0, HLT, 3'd4, 12'h000, 1'b0);
        s(1'b0, 1'b1, HLT, 3'd4, 12'h000, 1'b0);
        for (int i = 0; i < 20; i++)
            s(1'b0, 1'(i % 3 != 0), (i % 2 == 0) ? HLT : ADD, 3'd7, 12'h000, 1'b0);

        // Reset out of HALT, then 257 NOPs wrap the 8-bit counter to 1.
        do_reset();
        s(1'b0, 1'b1, NOP, 3'd0, 12'h000, 1'b0);
        for (int i = 0; i < 257; i++) run_instr(NOP, 12'h000, 12'h000, 12'h000);
        s(1'b0, 1'b0, NOP, 3'd1, 12'h000, 1'b0);

        // Reset during T5 of an ADD: back to IDLE, count cleared, restart.
        do_reset();
        s(1'b0, 1'b1, ADD, 3'd0, 12'h000, 1'b0);
        run_instr(ADD, IR_EN | MAR_LOAD, RAM_EN | B_LOAD, ALU_EN | A_LOAD);
        s(1'b0, 1'b1, ADD, 3'd1, PC_EN | MAR_LOAD, 1'b0);
        s(1'b0, 1'b1, ADD, 3'd2, PC_INC, 1'b0);
        s(1'b0, 1'b1, ADD, 3'd3, RAM_EN | IR_LOAD, 1'b0);
        s(1'b0, 1'b1, ADD, 3'd4, IR_EN | MAR_LOAD, 1'b0);
        s(1'b1, 1'b1, ADD, 3'd5, RAM_EN | B_LOAD, 1'b0);
        s(1'b0, 1'b1, ADD, 3'd0, 12'h000, 1'b0);
        s(1'b0, 1'b0, ADD, 3'd1, 12'h000, 1'b0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
